pattern_lut_loader: RTL and testbench
=====================================

Name: pattern_lut_loader

Overview:
Host-side write/readback engine for the pattern-finder lookup tables. The per-pattern LUTs (pattern IDs 0x2..0xA, indexed by the comparator-code carry word, holding {quality, bend, qs} words) are writable RAMs. This block writes them, reads them back and bulk-clears them. Its host side is driven from VME register strobes. Its LUT side drives the write/read ports of the nine RAMs; the pattern finder keeps its own independent lookup ports.

Parameters:
MXADRB, 12, LUT address width (carry word width)
MXDATB, 18, LUT data width ({quality, bend, qs})
NPAT, 9, number of LUTs (pattern IDs PID_MIN..PID_MIN+NPAT-1)
PID_MIN, 2, lowest valid pattern ID

Ports:
clock  in  1  system clock, all logic on rising edge
reset_n  in  1  asynchronous active-low reset
host_pid  in  4  pattern ID to select, sampled on host_load_adr
host_adr  in  MXADRB  start address, sampled on host_load_adr
host_wdata  in  MXDATB  write data, sampled on host_wr
host_load_adr  in  1  strobe: load pointer and PID
host_wr  in  1  strobe: write one word at pointer, then increment pointer
host_rd  in  1  strobe: read one word at pointer, then increment pointer
host_clear  in  1  strobe: zero the entire selected LUT
err_clr  in  1  clears sticky error flags
host_rdata  out  MXDATB  last readback word
host_rd_valid  out  1  one-cycle pulse when host_rdata is updated
busy  out  1  high while any state other than IDLE is active
err_pid  out  1  sticky: loaded PID outside PID_MIN..PID_MIN+NPAT-1
err_wrap  out  1  sticky: pointer wrapped from 2^MXADRB-1 to 0 on host wr/rd
err_busy  out  1  sticky: a strobe arrived while busy
wr_count  out  MXADRB+1  host words written since last host_load_adr (saturating)
lut_we  out  NPAT  one-hot write enable; bit = pid-PID_MIN
lut_re  out  NPAT  one-hot read enable
lut_adr  out  MXADRB  LUT address
lut_wdata  out  MXDATB  LUT write data
lut_rdata  in  MXDATB  selected RAM read data, valid one clock after lut_re

Behaviour:
- All outputs are registered. During reset, every output and internal register is 0, state is IDLE, and pid_ok=0. An async assert mid-operation drops lut_we/lut_re immediately and aborts any write, read or clear; the RAM content of the aborted operation is not guaranteed.
- States: IDLE, WR, RD_ADR, RD_CAP, CLR.
- Strobes are acted on only in IDLE. A strobe in any other state is ignored and sets err_busy.
- Priority for simultaneous strobes in IDLE: load_adr > clear > wr > rd. Losing strobes are dropped silently.
- host_load_adr: ptr<=host_adr, pid<=host_pid, wr_count<=0. pid_ok<=PID in range; if out of range, err_pid<=1. Stays in IDLE.
- host_wr/host_rd/host_clear with pid_ok=0: ignored, and err_pid<=1.
- WR (1 cycle):
  - On entry: lut_we[pid-PID_MIN]=1, lut_adr=ptr, lut_wdata=latched host_wdata.
  - On exit: ptr<=ptr+1, wr_count increments (saturating at 2^MXADRB); if ptr was all-ones, err_wrap<=1.
  - Next state IDLE. Strobe at edge N -> lut_we high in cycle N+1.
- RD_ADR (1 cycle): lut_re one-hot, lut_adr=ptr.
- RD_CAP (1 cycle): host_rdata<=lut_rdata, host_rd_valid pulses in the following cycle, ptr<=ptr+1; wrap sets err_wrap. Next state IDLE. Strobe at edge N -> host_rd_valid high in cycle N+3.
- CLR:
  - Counter runs 0..2^MXADRB-1 at one word per cycle: lut_we one-hot, lut_adr=counter, lut_wdata=0.
  - After the last address: ptr<=0, state IDLE. err_wrap is not set and wr_count is unchanged.
  - busy is high for exactly 2^MXADRB cycles.
- lut_we and lut_re are never both high, and never more than one bit of either is high.
- err_clr clears all three sticky flags. If an error event and err_clr occur in the same cycle, the error event wins (flag stays set).
- Only address and data move through this block; it does not interpret {quality, bend, qs}.

Test Plan:
- Reset, then load_adr pid=0xA adr=0x000, wr 0x3FFFF -> lut_we=0x100 for 1 cycle, lut_adr=0, lut_wdata=0x3FFFF, wr_count=1, busy high 1 cycle.
- load_adr pid=0x2 adr=0xFFF, then two wr -> addresses 0xFFF then 0x000, err_wrap=1 after the first write, lut_we=0x001 both times; err_clr -> err_wrap=0.
- load_adr pid=0x5 adr=0x123, rd with RAM model returning 0x0ABCD -> lut_re=0x008 in cycle N+1, host_rdata=0x0ABCD and host_rd_valid in cycle N+3, next read uses adr 0x124.
- load_adr pid=0xB -> err_pid=1; subsequent wr produces no lut_we pulse. load_adr pid=0x3 -> pid_ok, writes resume (err_pid stays set until err_clr).
- clear on pid=0x7 -> 4096 consecutive cycles of lut_we=0x020, adr 0..0xFFF, data 0. A wr strobe mid-clear sets err_busy and is not executed. ptr=0 afterward.
- Assert reset_n low in the middle of a clear -> lut_we=0 asynchronously, busy=0. After release, state is IDLE and all flags are 0.

Source files
------------

// File: rtl/pattern_lut_loader.sv
// Host write/readback/bulk-clear engine for the nine pattern-finder LUT RAMs.
// Latency: a write reaches the RAM one cycle after its strobe; readback data arrives three cycles after the strobe; a clear takes 2^MXADRB cycles.
// Backpressure: none; a strobe that arrives while busy is dropped and sets the sticky err_busy flag.
module pattern_lut_loader #(
  parameter int MXADRB  = 12,
  parameter int MXDATB  = 18,
  parameter int NPAT    = 9,
  parameter int PID_MIN = 2
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [3:0]        host_pid,
  input  logic [MXADRB-1:0] host_adr,
  input  logic [MXDATB-1:0] host_wdata,
  input  logic              host_load_adr,
  input  logic              host_wr,
  input  logic              host_rd,
  input  logic              host_clear,
  input  logic              err_clr,
  output logic [MXDATB-1:0] host_rdata,
  output logic              host_rd_valid,
  output logic              busy,
  output logic              err_pid,
  output logic              err_wrap,
  output logic              err_busy,
  output logic [MXADRB:0]   wr_count,
  output logic [NPAT-1:0]   lut_we,
  output logic [NPAT-1:0]   lut_re,
  output logic [MXADRB-1:0] lut_adr,
  output logic [MXDATB-1:0] lut_wdata,
  input  logic [MXDATB-1:0] lut_rdata
);

  localparam logic [3:0]      PID_LO = 4'(PID_MIN);
  localparam logic [3:0]      PID_HI = 4'(PID_MIN + NPAT - 1);
  localparam logic [MXADRB:0] WC_MAX = {1'b1, {MXADRB{1'b0}}};

  typedef enum logic [2:0] {IDLE, WR, RD_ADR, RD_CAP, CLR} state_t;

  state_t            state;
  logic [MXADRB-1:0] ptr;
  logic [MXADRB-1:0] clr_cnt;
  logic [NPAT-1:0]   pid_sel;
  logic              pid_ok;

  logic              pid_in_range;
  logic [3:0]        pid_idx;
  logic [NPAT-1:0]   new_sel;
  logic              in_idle;
  logic              act;
  logic              do_load;
  logic              do_clear;
  logic              do_wr;
  logic              do_rd;
  logic              set_pid;
  logic              set_busy;
  logic              set_wrap;

  // Strobe decode: load beats clear beats write beats read; error events.
  always_comb begin
    pid_in_range = (host_pid >= PID_LO) && (host_pid <= PID_HI);
    pid_idx      = host_pid - PID_LO;
    new_sel      = pid_in_range ? (NPAT'(1) << pid_idx) : '0;
    in_idle      = (state == IDLE);
    do_load      = in_idle && host_load_adr;
    act          = in_idle && !host_load_adr && (host_clear || host_wr || host_rd);
    do_clear     = act && pid_ok && host_clear;
    do_wr        = act && pid_ok && !host_clear && host_wr;
    do_rd        = act && pid_ok && !host_clear && !host_wr && host_rd;
    set_pid      = (do_load && !pid_in_range) || (act && !pid_ok);
    set_busy     = !in_idle && (host_load_adr || host_wr || host_rd || host_clear);
    set_wrap     = ((state == WR) || (state == RD_CAP)) && (ptr == '1);
  end

  // Control FSM with registered LUT/host outputs and sticky error flags.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      ptr           <= '0;
      clr_cnt       <= '0;
      pid_sel       <= '0;
      pid_ok        <= 1'b0;
      host_rdata    <= '0;
      host_rd_valid <= 1'b0;
      busy          <= 1'b0;
      err_pid       <= 1'b0;
      err_wrap      <= 1'b0;
      err_busy      <= 1'b0;
      wr_count      <= '0;
      lut_we        <= '0;
      lut_re        <= '0;
      lut_adr       <= '0;
      lut_wdata     <= '0;
    end else begin
      // An error event in the same cycle as err_clr keeps the flag set.
      err_pid       <= set_pid  || (err_pid  && !err_clr);
      err_wrap      <= set_wrap || (err_wrap && !err_clr);
      err_busy      <= set_busy || (err_busy && !err_clr);
      host_rd_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (do_load) begin
            ptr      <= host_adr;
            pid_sel  <= new_sel;
            pid_ok   <= pid_in_range;
            wr_count <= '0;
          end else if (do_clear) begin
            state     <= CLR;
            busy      <= 1'b1;
            clr_cnt   <= '0;
            lut_we    <= pid_sel;
            lut_adr   <= '0;
            lut_wdata <= '0;
          end else if (do_wr) begin
            state     <= WR;
            busy      <= 1'b1;
            lut_we    <= pid_sel;
            lut_adr   <= ptr;
            lut_wdata <= host_wdata;
          end else if (do_rd) begin
            state   <= RD_ADR;
            busy    <= 1'b1;
            lut_re  <= pid_sel;
            lut_adr <= ptr;
          end
        end
        WR: begin
          lut_we <= '0;
          ptr    <= ptr + 1'b1;
          if (wr_count != WC_MAX) wr_count <= wr_count + 1'b1;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        RD_ADR: begin
          lut_re <= '0;
          state  <= RD_CAP;
        end
        RD_CAP: begin
          host_rdata    <= lut_rdata;
          host_rd_valid <= 1'b1;
          ptr           <= ptr + 1'b1;
          busy          <= 1'b0;
          state         <= IDLE;
        end
        CLR: begin
          if (clr_cnt == '1) begin
            lut_we <= '0;
            ptr    <= '0;
            busy   <= 1'b0;
            state  <= IDLE;
          end else begin
            clr_cnt <= clr_cnt + 1'b1;
            lut_adr <= clr_cnt + 1'b1;
          end
        end
        default: begin
          lut_we <= '0;
          lut_re <= '0;
          busy   <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pattern_lut_loader.sv
// Directed bench for pattern_lut_loader with a one-cycle-latency RAM read model.
module tb_pattern_lut_loader;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [3:0]  host_pid;
  logic [11:0] host_adr;
  logic [17:0] host_wdata;
  logic        host_load_adr, host_wr, host_rd, host_clear, err_clr;
  logic [17:0] host_rdata;
  logic        host_rd_valid, busy, err_pid, err_wrap, err_busy;
  logic [12:0] wr_count;
  logic [8:0]  lut_we, lut_re;
  logic [11:0] lut_adr;
  logic [17:0] lut_wdata;
  logic [17:0] lut_rdata;
  logic [17:0] rd_return;

  int n_assert = 0;
  int n_fail   = 0;

  pattern_lut_loader dut (
    .clock(clock), .reset_n(reset_n),
    .host_pid(host_pid), .host_adr(host_adr), .host_wdata(host_wdata),
    .host_load_adr(host_load_adr), .host_wr(host_wr), .host_rd(host_rd),
    .host_clear(host_clear), .err_clr(err_clr),
    .host_rdata(host_rdata), .host_rd_valid(host_rd_valid), .busy(busy),
    .err_pid(err_pid), .err_wrap(err_wrap), .err_busy(err_busy),
    .wr_count(wr_count), .lut_we(lut_we), .lut_re(lut_re),
    .lut_adr(lut_adr), .lut_wdata(lut_wdata), .lut_rdata(lut_rdata)
  );

  always #5 clock = ~clock;

  // RAM read model: returns rd_return one clock after any lut_re bit.
  always @(posedge clock) begin
    if (lut_re != '0) lut_rdata <= rd_return;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic load(input logic [3:0] pid, input logic [11:0] adr);
    host_pid = pid; host_adr = adr; host_load_adr = 1'b1;
    tick();
    host_load_adr = 1'b0;
  endtask

  task automatic strobe_wr(input logic [17:0] d);
    host_wdata = d; host_wr = 1'b1;
    tick();
    host_wr = 1'b0;
  endtask

  task automatic strobe_rd();
    host_rd = 1'b1;
    tick();
    host_rd = 1'b0;
  endtask

  task automatic pulse_err_clr();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
  endtask

  initial begin
    int bad;
    reset_n = 1'b0; host_pid = '0; host_adr = '0; host_wdata = '0;
    host_load_adr = 0; host_wr = 0; host_rd = 0; host_clear = 0; err_clr = 0;
    rd_return = '0; lut_rdata = '0;
    tick(); tick();
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_we", 32'(lut_we), 32'h0);
    chk("rst_errs", 32'({err_pid, err_wrap, err_busy}), 32'h0);
    chk("rst_wrcnt", 32'(wr_count), 32'h0);
    reset_n = 1'b1;
    tick();

    // Single write to PID 0xA at address 0.
    load(4'hA, 12'h000);
    strobe_wr(18'h3FFFF);
    chk("w1_we", 32'(lut_we), 32'h100);
    chk("w1_adr", 32'(lut_adr), 32'h000);
    chk("w1_dat", 32'(lut_wdata), 32'h3FFFF);
    chk("w1_busy", 32'(busy), 32'h1);
    tick();
    chk("w1_we_off", 32'(lut_we), 32'h0);
    chk("w1_busy_off", 32'(busy), 32'h0);
    chk("w1_wrcnt", 32'(wr_count), 32'h1);

    // Pointer wrap on PID 0x2.
    load(4'h2, 12'hFFF);
    chk("wrap_wrcnt_clr", 32'(wr_count), 32'h0);
    strobe_wr(18'h11111);
    chk("wrap_we0", 32'(lut_we), 32'h001);
    chk("wrap_adr0", 32'(lut_adr), 32'hFFF);
    tick();
    chk("wrap_flag", 32'(err_wrap), 32'h1);
    strobe_wr(18'h22222);
    chk("wrap_we1", 32'(lut_we), 32'h001);
    chk("wrap_adr1", 32'(lut_adr), 32'h000);
    tick();
    chk("wrap_wrcnt", 32'(wr_count), 32'h2);
    pulse_err_clr();
    chk("wrap_clr", 32'(err_wrap), 32'h0);

    // Readback on PID 0x5 from 0x123, then 0x124.
    load(4'h5, 12'h123);
    rd_return = 18'h0ABCD;
    strobe_rd();
    chk("rd_re", 32'(lut_re), 32'h008);
    chk("rd_adr", 32'(lut_adr), 32'h123);
    chk("rd_we", 32'(lut_we), 32'h0);
    tick();
    chk("rd_re_off", 32'(lut_re), 32'h0);
    chk("rd_vld_early", 32'(host_rd_valid), 32'h0);
    tick();
    chk("rd_vld", 32'(host_rd_valid), 32'h1);
    chk("rd_data", 32'(host_rdata), 32'h0ABCD);
    tick();
    chk("rd_vld_pulse", 32'(host_rd_valid), 32'h0);
    rd_return = 18'h01234;
    strobe_rd();
    chk("rd2_adr", 32'(lut_adr), 32'h124);
    tick(); tick();
    chk("rd2_data", 32'(host_rdata), 32'h01234);

    // Bad PID blocks writes; a good PID re-enables them.
    load(4'hB, 12'h000);
    chk("pid_err", 32'(err_pid), 32'h1);
    strobe_wr(18'h00055);
    chk("pid_no_we", 32'(lut_we), 32'h0);
    chk("pid_no_busy", 32'(busy), 32'h0);
    load(4'h3, 12'h010);
    strobe_wr(18'h00055);
    chk("pid_ok_we", 32'(lut_we), 32'h002);
    chk("pid_ok_adr", 32'(lut_adr), 32'h010);
    tick();
    chk("pid_sticky", 32'(err_pid), 32'h1);
    pulse_err_clr();
    chk("pid_clr", 32'(err_pid), 32'h0);

    // Load beats a simultaneous write strobe.
    host_pid = 4'h3; host_adr = 12'h020; host_load_adr = 1'b1; host_wr = 1'b1;
    tick();
    host_load_adr = 1'b0; host_wr = 1'b0;
    chk("prio_no_we", 32'(lut_we), 32'h0);
    chk("prio_no_busy", 32'(busy), 32'h0);

    // Full clear of PID 0x7 with a write strobe arriving mid-clear.
    load(4'h7, 12'h555);
    host_clear = 1'b1;
    tick();
    host_clear = 1'b0;
    bad = 0;
    for (int i = 0; i < 4096; i++) begin
      if (lut_we !== 9'h020 || lut_adr !== 12'(i) || lut_wdata !== 18'h0 || busy !== 1'b1) bad++;
      host_wr = (i == 100);
      host_wdata = 18'h3AAAA;
      tick();
    end
    host_wr = 1'b0;
    chk("clr_seq_bad", 32'(bad), 32'h0);
    chk("clr_done_we", 32'(lut_we), 32'h0);
    chk("clr_done_busy", 32'(busy), 32'h0);
    chk("clr_err_busy", 32'(err_busy), 32'h1);
    chk("clr_err_wrap", 32'(err_wrap), 32'h0);
    chk("clr_wrcnt", 32'(wr_count), 32'h0);
    strobe_wr(18'h00001);
    chk("clr_ptr0_adr", 32'(lut_adr), 32'h000);
    chk("clr_ptr0_we", 32'(lut_we), 32'h020);
    tick();

    // Asynchronous reset in the middle of a clear.
    host_clear = 1'b1;
    tick();
    host_clear = 1'b0;
    for (int i = 0; i < 50; i++) tick();
    chk("arst_pre_busy", 32'(busy), 32'h1);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_we", 32'(lut_we), 32'h0);
    chk("arst_busy", 32'(busy), 32'h0);
    tick();
    reset_n = 1'b1;
    tick();
    chk("arst_errs", 32'({err_pid, err_wrap, err_busy}), 32'h0);
    chk("arst_busy_after", 32'(busy), 32'h0);
    load(4'h7, 12'h00A);
    strobe_wr(18'h00FF0);
    chk("arst_idle_we", 32'(lut_we), 32'h020);
    chk("arst_idle_adr", 32'(lut_adr), 32'h00A);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
